// File: rtl/misao_mem_responder_if.sv
// CPU bus and boot-loader stream bundle for the misao memory responder.
// master = CPU/loader side (drives strobes and bytes), slave = responder.
interface misao_mem_responder_if;
    logic        mem_enable_read;
    logic        mem_enable_write;
    logic        mem_rw;
    logic [14:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        cpu_rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        running;
    logic        oob_err;

    modport master (
        output mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out,
        output ld_valid, ld_data, ld_last,
        input  mem_data_in, cpu_rst, ld_ready, running, oob_err
    );

    modport slave (
        input  mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out,
        input  ld_valid, ld_data, ld_last,
        output mem_data_in, cpu_rst, ld_ready, running, oob_err
    );
endinterface

// File: rtl/misao_mem_responder.sv
// Byte RAM answering misao CPU strobes; clears itself, then boot-loads from a byte stream.
// Latency: CPU reads are combinational, writes land on the next rising edge.
// Backpressure: ld_ready is high only in LOAD; the CPU is held in reset until the image is in.
module misao_mem_responder #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    misao_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [AW-1:0]   ld_ptr_q, ld_ptr_d;
    logic            cpu_rst_q, ld_ready_q, running_q;
    logic            oob_q, oob_d;

    logic [7:0]      ram_q [DEPTH];
    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [7:0]      ram_wdata;
    logic [7:0]      rdata;
    logic            in_range;
    logic            unused_rw;

    // The direction hint carries no meaning here; the strobes decide everything.
    assign unused_rw = bus.mem_rw;
    assign in_range  = (32'(bus.mem_addr) < DEPTH);

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        oob_d     = oob_q;
        ram_we    = 1'b0;
        ram_waddr = clr_ptr_q;
        ram_wdata = 8'h00;
        rdata     = 8'h00;
        unique case (state_q)
            S_CLEAR: begin
                ram_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (bus.ld_valid && ld_ready_q) begin
                    ram_we    = 1'b1;
                    ram_waddr = ld_ptr_q;
                    ram_wdata = bus.ld_data;
                    ld_ptr_d  = ld_ptr_q + 1'b1;
                    if (bus.ld_last || ld_ptr_q == LAST) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_range) begin
                    if (bus.mem_enable_read) rdata = ram_q[bus.mem_addr[AW-1:0]];
                    if (bus.mem_enable_write) begin
                        ram_we    = 1'b1;
                        ram_waddr = bus.mem_addr[AW-1:0];
                        ram_wdata = bus.mem_data_out;
                    end
                end else if (bus.mem_enable_read || bus.mem_enable_write) begin
                    oob_d = 1'b1;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_CLEAR;
            clr_ptr_q  <= '0;
            ld_ptr_q   <= '0;
            cpu_rst_q  <= 1'b1;
            ld_ready_q <= 1'b0;
            running_q  <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ld_ptr_q   <= ld_ptr_d;
            cpu_rst_q  <= (state_d != S_RUN);
            ld_ready_q <= (state_d == S_LOAD);
            running_q  <= (state_d == S_RUN);
            oob_q      <= oob_d;
        end
    end

    // RAM has no reset of its own; the CLEAR sweep zeroes it after every rst_n.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end

    assign bus.mem_data_in = rdata;
    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.running     = running_q;
    assign bus.oob_err     = oob_q;

endmodule

// File: tb/tb_misao_mem_responder.sv
// Bench for misao_mem_responder: reset/clear timing, boot load, gapped loading,
// CPU read/write ordering, out-of-range handling and reset during RUN.
module tb_misao_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    misao_mem_responder_if b();

    misao_mem_responder #(.DEPTH(256), .AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        re;
        logic        we;
        logic        rw;
        logic [14:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic        exp_oob;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.mem_enable_read  = 1'b0;
        b.mem_enable_write = 1'b0;
        b.mem_rw           = 1'b0;
        b.mem_addr         = '0;
        b.mem_data_out     = '0;
        b.ld_valid         = 1'b0;
        b.ld_data          = '0;
        b.ld_last          = 1'b0;
    endtask

    // One CPU bus cycle: expected read byte queued at drive time, compared once settled.
    task automatic cpu_op(input string nm, input logic re, input logic we, input logic rw,
                          input logic [14:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
        b.mem_enable_read  = re;
        b.mem_enable_write = we;
        b.mem_rw           = rw;
        b.mem_addr         = addr;
        b.mem_data_out     = wd;
        exp_q.push_back(exp_rd);
        #1;
        check(nm, 32'(b.mem_data_in), 32'(exp_q.pop_front()));
        tick();
        b.mem_enable_read  = 1'b0;
        b.mem_enable_write = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        b.ld_valid = 1'b1;
        b.ld_data  = d;
        b.ld_last  = last;
        tick();
        b.ld_valid = 1'b0;
        b.ld_last  = 1'b0;
    endtask

    task automatic reset_and_clear(input string tag);
        int n;
        int bad;
        idle();
        rst_n = 1'b0;
        tick();
        check({tag, "_rst_cpu_rst"}, 32'(b.cpu_rst), 32'd1);
        check({tag, "_rst_ld_ready"}, 32'(b.ld_ready), 32'd0);
        check({tag, "_rst_running"}, 32'(b.running), 32'd0);
        check({tag, "_rst_oob"}, 32'(b.oob_err), 32'd0);
        rst_n = 1'b1;
        n = 0;
        bad = 0;
        while (b.ld_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
            if (b.cpu_rst !== 1'b1 || b.running !== 1'b0) bad++;
        end
        check({tag, "_clear_cycles"}, 32'(n), 32'd256);
        check({tag, "_clear_held"}, 32'(bad), 32'd0);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_running"}, 32'(b.running), 32'd1);
        check({tag, "_cpu_rst"}, 32'(b.cpu_rst), 32'd0);
        check({tag, "_ld_ready"}, 32'(b.ld_ready), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // CPU bus sequence in RUN after loading A0,4C,51 (ld_ptr then 3).
        vt[0]  = '{re:1, we:0, rw:0, addr:15'h0001, wd:8'h00, exp_rd:8'h4C, exp_oob:0};
        vt[1]  = '{re:1, we:0, rw:0, addr:15'h0002, wd:8'h00, exp_rd:8'h51, exp_oob:0};
        vt[2]  = '{re:1, we:0, rw:0, addr:15'h0003, wd:8'h00, exp_rd:8'h00, exp_oob:0};
        vt[3]  = '{re:0, we:1, rw:1, addr:15'h0010, wd:8'h5A, exp_rd:8'h00, exp_oob:0};
        vt[4]  = '{re:1, we:0, rw:0, addr:15'h0010, wd:8'h00, exp_rd:8'h5A, exp_oob:0};
        vt[5]  = '{re:1, we:1, rw:1, addr:15'h0010, wd:8'h33, exp_rd:8'h5A, exp_oob:0};
        vt[6]  = '{re:1, we:0, rw:1, addr:15'h0010, wd:8'h00, exp_rd:8'h33, exp_oob:0};
        vt[7]  = '{re:0, we:0, rw:0, addr:15'h0010, wd:8'h00, exp_rd:8'h00, exp_oob:0};
        vt[8]  = '{re:1, we:0, rw:0, addr:15'h00FF, wd:8'h00, exp_rd:8'h00, exp_oob:0};
        vt[9]  = '{re:0, we:1, rw:0, addr:15'h00FF, wd:8'hC3, exp_rd:8'h00, exp_oob:0};
        vt[10] = '{re:1, we:0, rw:0, addr:15'h00FF, wd:8'h00, exp_rd:8'hC3, exp_oob:0};
        vt[11] = '{re:1, we:0, rw:0, addr:15'h0100, wd:8'h00, exp_rd:8'h00, exp_oob:1};
        vt[12] = '{re:0, we:1, rw:1, addr:15'h7FFF, wd:8'h77, exp_rd:8'h00, exp_oob:1};
        vt[13] = '{re:1, we:0, rw:0, addr:15'h00FF, wd:8'h00, exp_rd:8'hC3, exp_oob:1};
        vt[14] = '{re:1, we:0, rw:0, addr:15'h0000, wd:8'h00, exp_rd:8'hA0, exp_oob:1};
        vt[15] = '{re:1, we:0, rw:0, addr:15'h0102, wd:8'h00, exp_rd:8'h00, exp_oob:1};
        vt[16] = '{re:1, we:0, rw:0, addr:15'h0001, wd:8'h00, exp_rd:8'h4C, exp_oob:1};

        idle();

        // Clear, zero-byte load, whole RAM reads back zero.
        reset_and_clear("a");
        load_byte(8'h00, 1'b1);
        check_run("a");
        for (int a = 0; a < 256; a++)
            cpu_op($sformatf("zero_rd_%0h", a), 1'b1, 1'b0, 1'b0, 15'(a), 8'h00, 8'h00);

        // Gapped load; bus activity and ld_last without ld_valid during LOAD must do nothing.
        reset_and_clear("b");
        load_byte(8'h11, 1'b0);
        b.ld_data = 8'hEE; b.ld_last = 1'b1;
        b.mem_enable_write = 1'b1; b.mem_enable_read = 1'b1;
        b.mem_addr = 15'h0020; b.mem_data_out = 8'hCC;
        #1;
        check("load_bus_rd", 32'(b.mem_data_in), 32'h00);
        tick();
        b.mem_enable_write = 1'b0; b.mem_addr = 15'h0200;
        tick();
        idle();
        check("gap_ld_ready", 32'(b.ld_ready), 32'd1);
        load_byte(8'h22, 1'b0);
        check("gap_still_load", 32'(b.running), 32'd0);
        load_byte(8'h33, 1'b1);
        check_run("b");
        check("b_oob_untouched", 32'(b.oob_err), 32'd0);
        cpu_op("gap_rd0", 1'b1, 1'b0, 1'b0, 15'h0000, 8'h00, 8'h11);
        cpu_op("gap_rd1", 1'b1, 1'b0, 1'b0, 15'h0001, 8'h00, 8'h22);
        cpu_op("gap_rd2", 1'b1, 1'b0, 1'b0, 15'h0002, 8'h00, 8'h33);
        cpu_op("gap_rd3", 1'b1, 1'b0, 1'b0, 15'h0003, 8'h00, 8'h00);
        cpu_op("load_wr_dropped", 1'b1, 1'b0, 1'b0, 15'h0020, 8'h00, 8'h00);

        // Boot image A0,4C,51, then loader traffic in RUN is ignored.
        reset_and_clear("c");
        load_byte(8'hA0, 1'b0);
        check("c_after1_running", 32'(b.running), 32'd0);
        check("c_after1_ld_ready", 32'(b.ld_ready), 32'd1);
        load_byte(8'h4C, 1'b0);
        load_byte(8'h51, 1'b1);
        check_run("c");
        load_byte(8'hEE, 1'b0);
        check("run_ld_ready", 32'(b.ld_ready), 32'd0);

        for (int i = 0; i < 17; i++) begin
            cpu_op($sformatf("vec%0d_rd", i), vt[i].re, vt[i].we, vt[i].rw,
                   vt[i].addr, vt[i].wd, vt[i].exp_rd);
            check($sformatf("vec%0d_oob", i), 32'(b.oob_err), 32'(vt[i].exp_oob));
        end

        // Reset pulse in RUN wipes the image and the sticky error.
        cpu_op("d_wr5", 1'b0, 1'b1, 1'b1, 15'h0005, 8'h99, 8'h00);
        cpu_op("d_rd5", 1'b1, 1'b0, 1'b0, 15'h0005, 8'h00, 8'h99);
        rst_n = 1'b0;
        #1;
        check("midrun_cpu_rst", 32'(b.cpu_rst), 32'd1);
        check("midrun_oob", 32'(b.oob_err), 32'd0);
        check("midrun_running", 32'(b.running), 32'd0);
        reset_and_clear("d");
        load_byte(8'h00, 1'b1);
        check_run("d");
        cpu_op("d_rd5_cleared", 1'b1, 1'b0, 1'b0, 15'h0005, 8'h00, 8'h00);
        cpu_op("d_rd10_cleared", 1'b1, 1'b0, 1'b0, 15'h0010, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
